// File: rtl/ccu_snoop_bcast_ctrl.sv
// ----------------------------------------------------------------------------
// ccu_snoop_bcast_ctrl
//
// Sequences one coherent snoop at a time from the CCU FSM to every ACE master
// except the initiator. The AC request is broadcast to all target ports, one
// CR is collected from each of them and the responses are OR-merged. At most
// one data-supplying port has its CD line forwarded downstream; CD beats from
// any other supplier are accepted and thrown away.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       snoop request from the CCU FSM
//   req_addr_i, req_snoop_i       snoop address and AC snoop type
//   req_init_i                    initiator port, excluded from the broadcast
//   ac_valid_o/ac_ready_i         per-port AC channel
//   ac_addr_o, ac_snoop_o         latched AC payload shared by all ports
//   cr_valid_i/cr_ready_o         per-port CR channel, cr_resp_i 5 bits/port
//   cd_valid_i/cd_ready_o         per-port CD channel, cd_data_i, cd_last_i
//   cd_valid_o/cd_ready_i         forwarded line beats, cd_data_o, cd_last_o
//   rsp_valid_o/rsp_ready_i       merged snoop result, rsp_o
//
// Handshake semantics (every channel): a transfer happens on a rising clock
// edge where valid and ready are both high. A source never drops valid or
// changes its payload before that transfer; ready may be raised or lowered
// freely and may depend combinationally on valid.
// ----------------------------------------------------------------------------
module ccu_snoop_bcast_ctrl #(
    parameter int NoPorts   = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 512,
    localparam int IdxWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [3:0]                     req_snoop_i,
    input  logic [IdxWidth-1:0]            req_init_i,
    output logic [NoPorts-1:0]             ac_valid_o,
    input  logic [NoPorts-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]           ac_addr_o,
    output logic [3:0]                     ac_snoop_o,
    input  logic [NoPorts-1:0]             cr_valid_i,
    output logic [NoPorts-1:0]             cr_ready_o,
    input  logic [NoPorts*5-1:0]           cr_resp_i,
    input  logic [NoPorts-1:0]             cd_valid_i,
    output logic [NoPorts-1:0]             cd_ready_o,
    input  logic [NoPorts*DataWidth-1:0]   cd_data_i,
    input  logic [NoPorts-1:0]             cd_last_i,
    output logic                           cd_valid_o,
    input  logic                           cd_ready_i,
    output logic [DataWidth-1:0]           cd_data_o,
    output logic                           cd_last_o,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [4:0]                     rsp_o
);

    localparam int Beats    = LineWidth / DataWidth;
    localparam int CntWidth = $clog2(Beats + 1);
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Beats - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AC   = 2'd1,
        ST_CD   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [NoPorts-1:0]    tgt_q, tgt_d;
    logic [NoPorts-1:0]    ac_done_q, ac_done_d;
    logic [NoPorts-1:0]    cr_done_q, cr_done_d;
    logic [NoPorts-1:0]    dt_q, dt_d;
    logic [NoPorts-1:0]    cd_done_q, cd_done_d;
    logic [4:0]            resp_q, resp_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [3:0]            snoop_q, snoop_d;
    logic [CntWidth-1:0]   beat_cnt_q [NoPorts];
    logic [CntWidth-1:0]   beat_cnt_d [NoPorts];

    logic [IdxWidth-1:0]   src;
    logic                  src_found;
    logic [NoPorts-1:0]    ac_hs, cr_hs, cd_hs;

    // The forwarding port is the lowest-indexed data supplier.
    always_comb begin
        src       = '0;
        src_found = 1'b0;
        for (int i = 0; i < NoPorts; i++) begin
            if (dt_q[i] && !src_found) begin
                src       = IdxWidth'(i);
                src_found = 1'b1;
            end
        end
    end

    assign ac_addr_o  = addr_q;
    assign ac_snoop_o = snoop_q;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        ac_done_d   = ac_done_q;
        cr_done_d   = cr_done_q;
        dt_d        = dt_q;
        cd_done_d   = cd_done_q;
        resp_d      = resp_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        beat_cnt_d  = beat_cnt_q;
        req_ready_o = 1'b0;
        ac_valid_o  = '0;
        cr_ready_o  = '0;
        cd_ready_o  = '0;
        cd_valid_o  = 1'b0;
        cd_data_o   = '0;
        cd_last_o   = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_o       = '0;
        ac_hs       = '0;
        cr_hs       = '0;
        cd_hs       = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    // An out-of-range initiator shifts the bit out, so every
                    // port becomes a target.
                    tgt_d     = ~({{(NoPorts-1){1'b0}}, 1'b1} << req_init_i);
                    addr_d    = req_addr_i;
                    snoop_d   = req_snoop_i;
                    ac_done_d = '0;
                    cr_done_d = '0;
                    dt_d      = '0;
                    cd_done_d = '0;
                    resp_d    = '0;
                    for (int i = 0; i < NoPorts; i++) begin
                        beat_cnt_d[i] = '0;
                    end
                    state_d = (tgt_d == '0) ? ST_RESP : ST_AC;
                end
            end

            ST_AC: begin
                ac_valid_o = tgt_q & ~ac_done_q;
                // A port may only answer once its own AC has been taken.
                cr_ready_o = ac_done_q & ~cr_done_q;
                ac_hs      = ac_valid_o & ac_ready_i;
                cr_hs      = cr_valid_i & cr_ready_o;
                ac_done_d  = ac_done_q | ac_hs;
                cr_done_d  = cr_done_q | cr_hs;
                for (int i = 0; i < NoPorts; i++) begin
                    if (cr_hs[i]) begin
                        resp_d  = resp_d | cr_resp_i[i*5 +: 5];
                        dt_d[i] = cr_resp_i[i*5];
                    end
                end
                if ((ac_done_d == tgt_q) && (cr_done_d == tgt_q)) begin
                    state_d = (dt_d == '0) ? ST_RESP : ST_CD;
                end
            end

            ST_CD: begin
                for (int i = 0; i < NoPorts; i++) begin
                    if (dt_q[i] && !cd_done_q[i]) begin
                        cd_ready_o[i] = (IdxWidth'(i) == src) ? cd_ready_i : 1'b1;
                    end
                end
                cd_valid_o = cd_valid_i[src] & ~cd_done_q[src];
                cd_data_o  = cd_data_i[src*DataWidth +: DataWidth];
                cd_last_o  = cd_last_i[src];
                cd_hs      = cd_valid_i & cd_ready_o;
                for (int i = 0; i < NoPorts; i++) begin
                    if (cd_hs[i]) begin
                        if (cd_last_i[i]) begin
                            cd_done_d[i] = 1'b1;
                            if (beat_cnt_q[i] != LastBeat) begin
                                resp_d[1] = 1'b1;
                            end
                        end else if (beat_cnt_q[i] == LastBeat) begin
                            // Full line seen without last: close the port so
                            // the snoop cannot hang on a broken master.
                            cd_done_d[i] = 1'b1;
                            resp_d[1]    = 1'b1;
                        end else begin
                            beat_cnt_d[i] = beat_cnt_q[i] + CntWidth'(1);
                        end
                    end
                end
                if (cd_done_d == dt_q) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_o       = resp_q;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            dt_q      <= '0;
            cd_done_q <= '0;
            resp_q    <= '0;
            addr_q    <= '0;
            snoop_q   <= '0;
            for (int i = 0; i < NoPorts; i++) begin
                beat_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            ac_done_q  <= ac_done_d;
            cr_done_q  <= cr_done_d;
            dt_q       <= dt_d;
            cd_done_q  <= cd_done_d;
            resp_q     <= resp_d;
            addr_q     <= addr_d;
            snoop_q    <= snoop_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ccu_snoop_bcast_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ccu_snoop_bcast_ctrl
//
// Directed scenarios followed by randomized snoops. Each snoop is planned up
// front (per-port CR value, CD line shape, AC/CR delays); the expected merged
// response and the forwarded beat sequence are computed from that plan and
// compared against what the DUT produces cycle by cycle.
// ----------------------------------------------------------------------------
module tb_ccu_snoop_bcast_ctrl;

    localparam int NP    = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LW    = 512;
    localparam int BEATS = LW / DW;
    localparam int IW    = (NP > 1) ? $clog2(NP) : 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                 req_valid, req_ready;
    logic [AW-1:0]        req_addr;
    logic [3:0]           req_snoop;
    logic [IW-1:0]        req_init;
    logic [NP-1:0]        ac_valid, ac_ready;
    logic [AW-1:0]        ac_addr;
    logic [3:0]           ac_snoop;
    logic [NP-1:0]        cr_valid, cr_ready;
    logic [NP*5-1:0]      cr_resp;
    logic [NP-1:0]        p_cd_valid, p_cd_ready, p_cd_last;
    logic [NP*DW-1:0]     p_cd_data;
    logic                 f_cd_valid, f_cd_ready, f_cd_last;
    logic [DW-1:0]        f_cd_data;
    logic                 rsp_valid, rsp_ready;
    logic [4:0]           rsp_o;

    ccu_snoop_bcast_ctrl #(
        .NoPorts   (NP),
        .AddrWidth (AW),
        .DataWidth (DW),
        .LineWidth (LW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_snoop_i (req_snoop),
        .req_init_i  (req_init),
        .ac_valid_o  (ac_valid),
        .ac_ready_i  (ac_ready),
        .ac_addr_o   (ac_addr),
        .ac_snoop_o  (ac_snoop),
        .cr_valid_i  (cr_valid),
        .cr_ready_o  (cr_ready),
        .cr_resp_i   (cr_resp),
        .cd_valid_i  (p_cd_valid),
        .cd_ready_o  (p_cd_ready),
        .cd_data_i   (p_cd_data),
        .cd_last_i   (p_cd_last),
        .cd_valid_o  (f_cd_valid),
        .cd_ready_i  (f_cd_ready),
        .cd_data_o   (f_cd_data),
        .cd_last_o   (f_cd_last),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_o       (rsp_o)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q[$];   // {last, data} of each beat expected downstream

    // ---------------- per-snoop plan ----------------
    logic [4:0]    cfg_resp     [NP];
    int            cfg_nbeats   [NP];
    bit            cfg_has_last [NP];
    int            cfg_ac_delay [NP];
    bit            cfg_cr_early [NP];
    logic [DW-1:0] cfg_data     [NP][BEATS];
    int            cfg_rsp_hold;
    int            cfg_abort_beat;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req_valid  = 1'b0;
        req_addr   = '0;
        req_snoop  = '0;
        req_init   = '0;
        ac_ready   = '0;
        cr_valid   = '0;
        cr_resp    = '0;
        p_cd_valid = '0;
        p_cd_data  = '0;
        p_cd_last  = '0;
        f_cd_ready = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic set_defaults();
        for (int p = 0; p < NP; p++) begin
            cfg_resp[p]     = 5'h00;
            cfg_nbeats[p]   = BEATS;
            cfg_has_last[p] = 1'b1;
            cfg_ac_delay[p] = 0;
            cfg_cr_early[p] = 1'b0;
            for (int b = 0; b < BEATS; b++) begin
                cfg_data[p][b] = {$urandom, $urandom};
            end
        end
        cfg_rsp_hold   = 0;
        cfg_abort_beat = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_ac_valid"},  ac_valid, '0);
        check({tag, "_cr_ready"},  cr_ready, '0);
        check({tag, "_cd_ready"},  p_cd_ready, '0);
        check({tag, "_cd_valid"},  f_cd_valid, 1'b0);
        check({tag, "_cd_data"},   f_cd_data, '0);
        check({tag, "_cd_last"},   f_cd_last, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp"},       rsp_o, '0);
        check({tag, "_ac_addr"},   ac_addr, '0);
        check({tag, "_ac_snoop"},  ac_snoop, '0);
    endtask

    // Runs one snoop from request to response. Entered and left just after a
    // rising edge with the DUT idle.
    task automatic run_snoop(input int init, input logic [3:0] snoop, input logic [AW-1:0] addr);
        logic [NP-1:0] tgt, dt, acked, cr_got, cd_pend, ac_hs, cr_hs, cd_hs;
        int            ac_wait [NP];
        int            cr_wait [NP];
        int            beat_i  [NP];
        logic [4:0]    exp_rsp, held;
        logic [DW:0]   exp_beat;
        int            src, cycles, hold_cnt, fwd;
        bit            done, fwd_hs, aborted, timed_out;

        // Reference: every port but the initiator is snooped; the merged
        // response is the OR of their CRs plus an error for any badly framed
        // line; the lowest supplier's line goes downstream as sent.
        tgt = '1;
        tgt[init] = 1'b0;
        exp_rsp = '0;
        dt      = '0;
        src     = -1;
        for (int p = 0; p < NP; p++) begin
            if (tgt[p]) begin
                exp_rsp |= cfg_resp[p];
                if (cfg_resp[p][0]) begin
                    dt[p] = 1'b1;
                    if (!cfg_has_last[p] || cfg_nbeats[p] != BEATS) exp_rsp[1] = 1'b1;
                    if (src < 0) src = p;
                end
            end
        end
        exp_q.delete();
        if (src >= 0) begin
            for (int b = 0; b < cfg_nbeats[src]; b++) begin
                exp_q.push_back({(cfg_has_last[src] && b == cfg_nbeats[src] - 1), cfg_data[src][b]});
            end
        end

        // request handshake
        req_valid = 1'b1;
        req_addr  = addr;
        req_snoop = snoop;
        req_init  = IW'(init);
        #1;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        acked = '0; cr_got = '0; cd_pend = '0;
        for (int p = 0; p < NP; p++) begin
            ac_wait[p] = cfg_ac_delay[p];
            cr_wait[p] = $urandom_range(0, 3);
            beat_i[p]  = 0;
        end
        held = '0; hold_cnt = 0; fwd = 0; cycles = 0;
        done = 1'b0; aborted = 1'b0; timed_out = 1'b0;

        while (!done) begin
            if (cfg_abort_beat >= 0 && fwd == cfg_abort_beat) begin
                aborted = 1'b1;
                break;
            end
            for (int p = 0; p < NP; p++) begin
                ac_ready[p] = (ac_wait[p] == 0);
                cr_valid[p] = tgt[p] && !cr_got[p] &&
                              (cfg_cr_early[p] || (acked[p] && cr_wait[p] == 0));
                cr_resp[p*5 +: 5] = cfg_resp[p];
                if (!cd_pend[p] && tgt[p] && cfg_resp[p][0] && cr_got[p] && beat_i[p] < cfg_nbeats[p])
                    cd_pend[p] = ($urandom_range(0, 3) != 0);
                p_cd_valid[p] = cd_pend[p];
                p_cd_data[p*DW +: DW] = (beat_i[p] < BEATS) ? cfg_data[p][beat_i[p]] : '0;
                p_cd_last[p] = cfg_has_last[p] && (beat_i[p] == cfg_nbeats[p] - 1);
            end
            f_cd_ready = ($urandom_range(0, 3) != 0);
            rsp_ready  = (hold_cnt >= cfg_rsp_hold);
            #1;

            if (cycles == 0) begin
                check("ac_addr", ac_addr, addr);
                check("ac_snoop", ac_snoop, snoop);
            end
            check("ac_valid", ac_valid, tgt & ~acked);
            check("req_ready_busy", req_ready, 1'b0);
            check("cd_ready_nondt", p_cd_ready & ~dt, '0);

            ac_hs  = ac_valid & ac_ready;
            cr_hs  = cr_valid & cr_ready;
            cd_hs  = p_cd_valid & p_cd_ready;
            fwd_hs = f_cd_valid && f_cd_ready;
            if (fwd_hs) begin
                check("cd_beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("cd_beat", {f_cd_last, f_cd_data}, exp_beat);
                end
            end
            if (rsp_valid) begin
                if (hold_cnt == 0) begin
                    held = rsp_o;
                    check("rsp", rsp_o, exp_rsp);
                    check("cd_drained", exp_q.size(), 0);
                end else begin
                    check("rsp_stable", rsp_o, held);
                end
                hold_cnt++;
                if (rsp_ready) done = 1'b1;
            end

            @(posedge clk); #1;
            acked  |= ac_hs;
            cr_got |= cr_hs;
            for (int p = 0; p < NP; p++) begin
                if (cd_hs[p]) begin
                    beat_i[p]++;
                    cd_pend[p] = 1'b0;
                end
                if (ac_wait[p] > 0) ac_wait[p]--;
                if (acked[p] && cr_wait[p] > 0) cr_wait[p]--;
            end
            if (fwd_hs) fwd++;
            cycles++;
            if (cycles > 3000) begin
                timed_out = 1'b1;
                check("timeout_cycles", cycles, 0);
                break;
            end
        end

        if (aborted || timed_out) begin
            #2;
            rst_n = 1'b0;
            #1;
            if (aborted) check_reset_outputs("abort");
            clear_inputs();
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            clear_inputs();
            #1;
            check("req_ready_after", req_ready, 1'b1);
            check("rsp_valid_after", rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int plan;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ReadShared, no data, all targets report IsShared
        set_defaults();
        for (int p = 1; p < NP; p++) cfg_resp[p] = 5'h08;
        run_snoop(0, 4'b0001, 64'h0000_1234_5678_9ac0);

        // 2: two suppliers, lower one forwarded, upper one drained
        set_defaults();
        cfg_resp[1] = 5'h05;
        cfg_resp[3] = 5'h05;
        run_snoop(2, 4'b0111, 64'hdead_beef_0000_0040);

        // 3: staggered AC ready, port1 CR raised with its AC
        set_defaults();
        cfg_ac_delay[3] = 10;
        cfg_ac_delay[2] = 3;
        cfg_cr_early[1] = 1'b1;
        cfg_resp[2]     = 5'h08;
        cfg_resp[3]     = 5'h10;
        run_snoop(0, 4'b1001, 64'h0000_0000_00ff_ff80);

        // 4: early last on beat 5 of 8
        set_defaults();
        cfg_resp[1]   = 5'h01;
        cfg_nbeats[1] = 6;
        run_snoop(0, 4'b0001, 64'h1111_2222_3333_4440);

        // 4b: line without last
        set_defaults();
        cfg_resp[2]     = 5'h01;
        cfg_has_last[2] = 1'b0;
        run_snoop(1, 4'b0001, 64'h0000_0000_0000_0100);

        // 5: response back-pressured for 20 cycles
        set_defaults();
        cfg_resp[3]  = 5'h0c;
        cfg_rsp_hold = 20;
        run_snoop(1, 4'b0010, 64'h0000_0000_0000_0200);

        // 6: reset during CD beat 3, then a normal snoop
        set_defaults();
        cfg_resp[1]    = 5'h01;
        cfg_abort_beat = 3;
        run_snoop(0, 4'b0001, 64'h0000_0000_0000_0300);
        set_defaults();
        cfg_resp[0] = 5'h05;
        cfg_resp[2] = 5'h09;
        run_snoop(3, 4'b0001, 64'h0000_0000_0000_0340);

        // randomized snoops
        for (int t = 0; t < 60; t++) begin
            set_defaults();
            for (int p = 0; p < NP; p++) begin
                cfg_resp[p]     = 5'($urandom_range(0, 31));
                cfg_ac_delay[p] = $urandom_range(0, 4);
                cfg_cr_early[p] = ($urandom_range(0, 3) == 0);
                plan = $urandom_range(0, 3);
                if (plan == 2) begin
                    cfg_nbeats[p] = $urandom_range(1, BEATS - 1);
                end else if (plan == 3) begin
                    cfg_has_last[p] = 1'b0;
                end
            end
            cfg_rsp_hold = $urandom_range(0, 3);
            run_snoop($urandom_range(0, NP - 1), 4'($urandom_range(0, 15)),
                      {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
